// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : com_pkg
//  Description : Shared types and widths for the center_of_mass pixel path
//                (com_feeder producer and center_of_mass consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
package com_pkg;

  localparam int X_W   = 11;  // column coordinate width
  localparam int Y_W   = 10;  // row coordinate width
  localparam int CNT_W = 20;  // selected-pixel count width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    TAB    = 2'd3
  } com_state_t;

endpackage
`default_nettype wire

// File: rtl/com_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : com_feeder
//  Description : Thresholds the camera luma stream, emits (x, y, valid) for
//                each dark pixel of a frame, then holds the tabulate strobe
//                until center_of_mass answers or the wait times out.
//  Revision    : 1.0 - initial release
// ============================================================================
module com_feeder
  import com_pkg::*;
#(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int FLUSH_CYCLES = 4,
  parameter int TAB_TIMEOUT  = 4096
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [X_W-1:0]   hcount_in,
  input  logic [Y_W-1:0]   vcount_in,
  input  logic [7:0]       pixel_in,
  input  logic             pixel_valid_in,
  input  logic [7:0]       threshold_in,
  input  logic             com_valid_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic             valid_out,
  output logic             tabulate_out,
  output logic             frame_done_out,
  output logic             empty_out,
  output logic             timeout_out,
  output logic [CNT_W-1:0] pixel_count_out,
  output logic             busy_out
);

  // One timer serves both the flush delay and the tabulate timeout.
  localparam int c_TMR_MAX = (FLUSH_CYCLES > TAB_TIMEOUT) ? FLUSH_CYCLES : TAB_TIMEOUT;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [X_W-1:0]     c_H_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]     c_V_LAST    = Y_W'(V_ACTIVE - 1);
  localparam logic [c_TMR_W-1:0] c_FLUSH_END = c_TMR_W'(FLUSH_CYCLES);
  localparam logic [c_TMR_W-1:0] c_TAB_END   = c_TMR_W'(TAB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;

  com_state_t         r_state, w_state_nxt;
  logic [7:0]         r_thr, w_thr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [X_W-1:0]     r_x, w_x_nxt;
  logic [Y_W-1:0]     r_y, w_y_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_tab, w_tab_nxt;
  logic               r_done, w_done_nxt;
  logic               r_empty, w_empty_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]   r_pcnt, w_pcnt_nxt;

  logic               w_first, w_last, w_start, w_take, w_sel;
  logic [7:0]         w_thr;
  logic [CNT_W-1:0]   w_base_cnt;

  // A (0,0) pixel in IDLE or STREAM opens a fresh frame: it uses the
  // incoming threshold and restarts the count, so a mid-frame resync
  // behaves exactly like a frame start.
  assign w_first    = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign w_last     = pixel_valid_in && (hcount_in == c_H_LAST) && (vcount_in == c_V_LAST);
  assign w_start    = w_first && ((r_state == IDLE) || (r_state == STREAM));
  assign w_take     = w_start || ((r_state == STREAM) && pixel_valid_in);
  assign w_thr      = w_start ? threshold_in : r_thr;
  assign w_base_cnt = w_start ? '0 : r_cnt;
  assign w_sel      = pixel_valid_in && (pixel_in < w_thr);

  // Next-state and next-output decode for the frame FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_thr_nxt     = r_thr;
    w_cnt_nxt     = r_cnt;
    w_tmr_nxt     = r_tmr;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_valid_nxt   = 1'b0;
    w_tab_nxt     = 1'b0;
    w_done_nxt    = 1'b0;
    w_empty_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_pcnt_nxt    = r_pcnt;
    case (r_state)
      IDLE, STREAM: begin
        if (w_take) begin
          w_thr_nxt = w_thr;
          w_cnt_nxt = w_base_cnt;
          if (w_sel) begin
            w_valid_nxt = 1'b1;
            w_x_nxt     = hcount_in;
            w_y_nxt     = vcount_in;
            if (w_base_cnt != c_CNT_MAX) begin
              w_cnt_nxt = w_base_cnt + CNT_W'(1);
            end
          end
          if (w_last) begin
            w_state_nxt = FLUSH;
            w_tmr_nxt   = '0;
          end else begin
            w_state_nxt = STREAM;
          end
        end
      end
      FLUSH: begin
        if (r_tmr == c_FLUSH_END) begin
          w_tmr_nxt = '0;
          if (r_cnt == '0) begin
            w_done_nxt  = 1'b1;
            w_empty_nxt = 1'b1;
            w_pcnt_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_tab_nxt   = 1'b1;
            w_state_nxt = TAB;
          end
        end else begin
          w_tmr_nxt = r_tmr + c_TMR_W'(1);
        end
      end
      TAB: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (com_valid_in) begin
          w_done_nxt  = 1'b1;
          w_pcnt_nxt  = r_cnt;
          w_state_nxt = IDLE;
        end else if (r_tmr == c_TAB_END) begin
          w_done_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_pcnt_nxt    = r_cnt;
          w_state_nxt   = IDLE;
        end else begin
          w_tab_nxt = 1'b1;
          w_tmr_nxt = r_tmr + c_TMR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_thr     <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_tab     <= 1'b0;
      r_done    <= 1'b0;
      r_empty   <= 1'b0;
      r_timeout <= 1'b0;
      r_pcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_thr     <= w_thr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmr     <= w_tmr_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_valid   <= w_valid_nxt;
      r_tab     <= w_tab_nxt;
      r_done    <= w_done_nxt;
      r_empty   <= w_empty_nxt;
      r_timeout <= w_timeout_nxt;
      r_pcnt    <= w_pcnt_nxt;
    end
  end

  assign x_out           = r_x;
  assign y_out           = r_y;
  assign valid_out       = r_valid;
  assign tabulate_out    = r_tab;
  assign frame_done_out  = r_done;
  assign empty_out       = r_empty;
  assign timeout_out     = r_timeout;
  assign pixel_count_out = r_pcnt;
  assign busy_out        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/com_feeder.md
Name: com_feeder

Overview:
- Producer end of the center_of_mass pixel interface: scans the camera pixel stream and thresholds luma to pick dark QR-module pixels.
- Emits (x, y, valid) for each selected pixel, then drives the tabulate strobe at end of frame and holds it until center_of_mass reports a result.
- Sits between the camera/pixel pipeline and center_of_mass; one frame is in flight at a time.

Parameters:
- H_ACTIVE, 1024, active pixels per line; last column is H_ACTIVE-1.
- V_ACTIVE, 768, active lines per frame; last row is V_ACTIVE-1.
- FLUSH_CYCLES, 4, idle cycles between the last valid_out and the rise of tabulate_out.
- TAB_TIMEOUT, 4096, maximum cycles tabulate_out stays high while waiting for com_valid_in.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-high reset.
- hcount_in, input, 11, column of the current pixel.
- vcount_in, input, 10, row of the current pixel.
- pixel_in, input, 8, luma of the current pixel.
- pixel_valid_in, input, 1, current pixel is valid.
- threshold_in, input, 8, pixel is selected when pixel_in < threshold_in; sampled at start of frame.
- com_valid_in, input, 1, valid_out from center_of_mass (result ready).
- x_out, output, 11, column of the selected pixel.
- y_out, output, 10, row of the selected pixel.
- valid_out, output, 1, x_out and y_out are valid.
- tabulate_out, output, 1, request center_of_mass to compute.
- frame_done_out, output, 1, one-cycle pulse when a frame completes.
- empty_out, output, 1, qualifies frame_done_out: the frame had 0 selected pixels.
- timeout_out, output, 1, one-cycle pulse when the tabulate wait expires.
- pixel_count_out, output, 20, selected-pixel count of the last frame; updates with frame_done_out.
- busy_out, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; every output 0; threshold register 0; running count 0.
- States and transitions:
  - IDLE -> STREAM on pixel_valid_in with (hcount_in, vcount_in)=(0,0). Latch threshold_in in the same cycle and treat this pixel as the first pixel of the frame.
  - STREAM: each pixel with pixel_valid_in and pixel_in < latched threshold gives valid_out=1 one cycle later (1-cycle registered latency), with x_out/y_out equal to that pixel's hcount_in/vcount_in.
  - STREAM: running count increments per selected pixel and saturates at 2^20-1.
  - STREAM: when x_out/y_out are not valid they hold their last value.
  - STREAM -> FLUSH on the valid pixel at (H_ACTIVE-1, V_ACTIVE-1); that pixel is still processed normally.
  - STREAM, resync: a valid pixel at (0,0) aborts the current frame. No tabulate, no frame_done. Count restarts, threshold is re-latched, and the (0,0) pixel is processed as a new frame. State stays STREAM.
  - FLUSH: counts FLUSH_CYCLES cycles, then:
    - if count=0: pulse frame_done_out with empty_out=1, pixel_count_out=0, go to IDLE; tabulate_out never rises.
    - otherwise: go to TAB.
  - TAB: tabulate_out=1 every cycle.
  - TAB, com_valid_in=1: the next cycle has tabulate_out=0, frame_done_out=1, empty_out=0, and pixel_count_out=count; go to IDLE.
  - TAB, no com_valid_in after TAB_TIMEOUT cycles: tabulate_out drops, timeout_out and frame_done_out pulse in the same cycle, pixel_count_out=count; go to IDLE.
  - TAB, simultaneous com_valid_in and timeout expiry: com_valid_in wins and timeout_out stays 0.
- Pixels in FLUSH, TAB and IDLE (other than (0,0) in IDLE) are ignored: valid_out=0.
- A frame that starts during TAB is dropped; capture resumes at the next (0,0) seen in IDLE.
- com_valid_in outside TAB is ignored.
- valid_out and tabulate_out are never high in the same cycle.
- Comparison is unsigned 8-bit. threshold_in=0 selects nothing, so that frame ends empty.

Decomposition:
- Shared package com_pkg holds:
  - state enum (IDLE, STREAM, FLUSH, TAB);
  - coordinate widths X_W=11, Y_W=10;
  - count width CNT_W=20.
- center_of_mass imports the same widths from com_pkg.
- No sub-module needed; the single FSM plus a flush/timeout counter shared between FLUSH and TAB is natural.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=2, threshold 128, pixels at odd columns=10, even columns=200 -> 8 valid_out pulses with x=1,3,5,7 on y=0 and y=1, each 1 cycle after input. tabulate_out rises 4 cycles after the last pixel; com_valid_in after 20 cycles -> frame_done_out with pixel_count_out=8, empty_out=0.
- Same frame with all pixels 255 -> no valid_out, no tabulate_out, frame_done_out with empty_out=1, pixel_count_out=0.
- TAB_TIMEOUT=16, com_valid_in held 0 -> tabulate_out high exactly 16 cycles; timeout_out and frame_done_out pulse together; busy_out=0 the next cycle.
- (0,0) pixel re-injected mid-frame after 5 selected pixels -> no tabulate for the aborted frame; the next complete frame reports only its own count.
- rst_in asserted during TAB, asynchronous between clock edges -> tabulate_out and busy_out fall immediately; the next (0,0) restarts capture cleanly.
- Integrated with center_of_mass on a 700x1 line, all pixels dark -> center_of_mass reports x≈350, y=0; frame_done_out with pixel_count_out=700.
